hack_cpu_mc: RTL and testbench

Multicycle, parametrised Hack CPU core for the project-5 computer generation. It executes standard Hack A- and C-instructions from an asynchronous-read instruction ROM. Data memory sits behind a req/ack handshake, so RAM, screen and keyboard maps with arbitrary wait states can attach. Over the fixed single-cycle computer it adds generalised data/address widths, a run/pause control, self-loop halt detection and a cycle counter for benches.

---
 rtl/hack_cpu_mc_if.sv | 22 ++
 rtl/hack_cpu_mc.sv | 137 +++++++++++++
 tb/tb_hack_cpu_mc.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_cpu_mc_if.sv
// Data-memory req/ack bus between the Hack core (master) and RAM/screen/keyboard maps (slave).
interface hack_cpu_mc_if #(
  parameter int WIDTH      = 16,
  parameter int RAM_ADDR_W = 15
);
  logic                  mem_req;
  logic                  mem_we;
  logic [RAM_ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU: 2 cycles per instruction, +1 per M read, +1 per M write, +1 per memory wait state.
// Memory backpressure: mem_req holds with stable addr/we/wdata until mem_ack; run=0 parks the core in FETCH.
module hack_cpu_mc #(
  parameter int WIDTH      = 16,
  parameter int ROM_ADDR_W = 15,
  parameter int RAM_ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  hack_cpu_mc_if.master         mem,
  output logic [WIDTH-1:0]      ARegister,
  output logic [WIDTH-1:0]      DRegister,
  output logic [ROM_ADDR_W-1:0] pc,
  output logic                  halted,
  output logic [31:0]           cycle_count
);

  typedef enum logic [2:0] {FETCH, MEM_RD, EXEC, MEM_WR, HALT} state_t;

  state_t                state, state_nxt;
  logic [15:0]           ir;
  logic [WIDTH-1:0]      a_reg, d_reg, m_reg, wdata_r;
  logic [RAM_ADDR_W-1:0] addr_r;
  logic [ROM_ADDR_W-1:0] pc_r, prev_a_pc, pc_inc;
  logic                  prev_a_vld, halt_pend;
  logic [31:0]           cyc;

  logic [WIDTH-1:0] alu_x0, alu_x1, alu_y, alu_y0, alu_y1, alu_f, alu_out;
  logic             zr, ng, jmp_taken, halt_hit, cyc_en;

  assign pc_inc = pc_r + ROM_ADDR_W'(1);

  always_comb begin
    alu_x0    = ir[11] ? '0 : d_reg;
    alu_x1    = ir[10] ? ~alu_x0 : alu_x0;
    alu_y     = ir[12] ? m_reg : a_reg;
    alu_y0    = ir[9] ? '0 : alu_y;
    alu_y1    = ir[8] ? ~alu_y0 : alu_y0;
    alu_f     = ir[7] ? (alu_x1 + alu_y1) : (alu_x1 & alu_y1);
    alu_out   = ir[6] ? ~alu_f : alu_f;
    zr        = (alu_out == '0);
    ng        = alu_out[WIDTH-1];
    jmp_taken = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
    // `@T / 0;JMP` at T+1: the A-instruction just executed pointed at itself.
    halt_hit  = prev_a_vld && jmp_taken && (a_reg[ROM_ADDR_W-1:0] == prev_a_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    case (state)
      FETCH:  if (run) state_nxt = (rom_data[15] && rom_data[12]) ? MEM_RD : EXEC;
      MEM_RD: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        if (!ir[15])      state_nxt = FETCH;
        else if (ir[3])   state_nxt = MEM_WR;
        else if (halt_hit) state_nxt = HALT;
        else              state_nxt = FETCH;
      end
      MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ack) state_nxt = halt_pend ? HALT : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign cyc_en = (state != HALT) && !(state == FETCH && !run);

  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      m_reg      <= '0;
      pc_r       <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      prev_a_pc  <= '0;
      prev_a_vld <= 1'b0;
      halt_pend  <= 1'b0;
      cyc        <= '0;
    end else begin
      if (cyc_en && cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;
      case (state)
        FETCH: if (run) begin
          ir <= rom_data;
          if (rom_data[15] && rom_data[12]) addr_r <= a_reg[RAM_ADDR_W-1:0];
        end
        MEM_RD: if (mem.mem_ack) m_reg <= mem.mem_rdata;
        EXEC: begin
          if (!ir[15]) begin
            a_reg      <= {{(WIDTH-15){1'b0}}, ir[14:0]};
            pc_r       <= pc_inc;
            prev_a_vld <= 1'b1;
            prev_a_pc  <= pc_r;
          end else begin
            if (ir[5]) a_reg <= alu_out;
            if (ir[4]) d_reg <= alu_out;
            pc_r       <= jmp_taken ? a_reg[ROM_ADDR_W-1:0] : pc_inc;
            prev_a_vld <= 1'b0;
            halt_pend  <= halt_hit;
            if (ir[3]) begin
              addr_r  <= a_reg[RAM_ADDR_W-1:0];
              wdata_r <= alu_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr      = pc_r;
  assign pc            = pc_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign ARegister     = a_reg;
  assign DRegister     = d_reg;
  assign halted        = (state == HALT);
  assign cycle_count   = cyc;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: memory transactions go through a scoreboard, final architectural state is checked directly.
module tb_hack_cpu_mc;
  logic        clk, reset, run, run32, stray, ack_en;
  int          ack_delay;
  logic [14:0] rom_addr, rom_addr32, pc, pc32;
  logic [15:0] rom_data, rom_data32, a16, d16;
  logic [31:0] a32, d32, cc, cc32;
  logic        halted, halted32;
  logic [15:0] rom   [0:63];
  logic [15:0] rom32 [0:63];
  logic [15:0] ram   [0:63];
  int          checks, errors, req_cnt;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    int          cycles;
  } exp_t;
  exp_t exp_q[$];

  hack_cpu_mc_if #(.WIDTH(16), .RAM_ADDR_W(15)) bus();
  hack_cpu_mc_if #(.WIDTH(32), .RAM_ADDR_W(15)) bus32();

  hack_cpu_mc #(.WIDTH(16), .ROM_ADDR_W(15), .RAM_ADDR_W(15)) dut (
    .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem(bus), .ARegister(a16), .DRegister(d16), .pc(pc), .halted(halted), .cycle_count(cc)
  );

  hack_cpu_mc #(.WIDTH(32), .ROM_ADDR_W(15), .RAM_ADDR_W(15)) dut32 (
    .clk(clk), .reset(reset), .run(run32), .rom_addr(rom_addr32), .rom_data(rom_data32),
    .mem(bus32), .ARegister(a32), .DRegister(d32), .pc(pc32), .halted(halted32), .cycle_count(cc32)
  );

  assign rom_data   = rom[rom_addr[5:0]];
  assign rom_data32 = rom32[rom_addr32[5:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles; stray drives an ack with no request.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus32.mem_ack = 1'b0;
    bus32.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stray && !bus.mem_req) begin
        bus.mem_ack = 1'b1;
      end else if (bus.mem_req && ack_en) begin
        if (wcnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = ram[bus.mem_addr[5:0]];
          wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: tracks each handshake and pops the scoreboard on its ack cycle.
  initial begin
    logic        in_hs, unstable;
    int          hs_cycles;
    logic [14:0] hs_addr;
    logic [15:0] hs_wdata;
    exp_t        e;
    in_hs = 1'b0;
    unstable = 1'b0;
    hs_cycles = 0;
    hs_addr = '0;
    hs_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        req_cnt++;
        if (!in_hs) begin
          in_hs = 1'b1;
          hs_cycles = 0;
          hs_addr = bus.mem_addr;
          hs_wdata = bus.mem_wdata;
          unstable = 1'b0;
        end
        hs_cycles++;
        if (bus.mem_addr !== hs_addr || bus.mem_wdata !== hs_wdata) unstable = 1'b1;
        if (bus.mem_ack) begin
          in_hs = 1'b0;
          if (bus.mem_we) ram[bus.mem_addr[5:0]] = bus.mem_wdata;
          if (exp_q.size() == 0) begin
            chk("unexpected access", 32'(bus.mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("access we", 32'(bus.mem_we), 32'(e.we));
            chk("access addr", 32'(bus.mem_addr), 32'(e.addr));
            if (e.we) chk("access wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            chk("req cycles", 32'(hs_cycles), 32'(e.cycles));
            chk("addr/wdata stable", 32'(unstable), 32'd0);
          end
        end
      end else begin
        in_hs = 1'b0;
      end
    end
  end

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask

  task automatic load_add();
    clear_rom();
    rom[0] = 16'd2;   rom[1] = 16'hEC10;  // @2  D=A
    rom[2] = 16'd3;   rom[3] = 16'hE090;  // @3  D=D+A
    rom[4] = 16'd0;   rom[5] = 16'hE308;  // @0  M=D
    rom[6] = 16'd6;   rom[7] = 16'hEA87;  // @6  0;JMP
  endtask

  task automatic push_exp(input logic we, input logic [14:0] addr, input logic [15:0] wdata, input int cyc);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    run32 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  initial begin
    int n;
    logic [14:0] pc_snap;
    logic [31:0] cc_snap;
    int req_snap;
    checks = 0; errors = 0; req_cnt = 0;
    reset = 1'b1; run = 1'b0; run32 = 1'b0; stray = 1'b0; ack_en = 1'b1; ack_delay = 0;
    foreach (ram[i]) ram[i] = 16'h0000;
    foreach (rom32[i]) rom32[i] = 16'h0000;
    clear_rom();

    // Reset state
    do_reset();
    chk("rst A", 32'(a16), 0);
    chk("rst D", 32'(d16), 0);
    chk("rst pc", 32'(pc), 0);
    chk("rst cycle_count", cc, 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst mem_req", 32'(bus.mem_req), 0);
    chk("rst mem_we", 32'(bus.mem_we), 0);
    chk("rst mem_addr", 32'(bus.mem_addr), 0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 0);

    // Add program, zero-wait memory
    load_add();
    push_exp(1'b1, 15'd0, 16'd5, 1);
    run = 1'b1;
    wait_halt(100, "add halted");
    chk("add D", 32'(d16), 5);
    chk("add pc", 32'(pc), 6);
    chk("add cycle_count", cc, 17);

    // Add program, ack in the third request cycle
    do_reset();
    ack_delay = 2;
    push_exp(1'b1, 15'd0, 16'd5, 3);
    run = 1'b1;
    wait_halt(100, "slow add halted");
    chk("slow add D", 32'(d16), 5);
    chk("slow add cycle_count", cc, 19);
    ack_delay = 0;

    // Read path: RAM[7]=10, D=M-1 stored to RAM[8]
    do_reset();
    clear_rom();
    ram[7] = 16'd10;
    rom[0] = 16'd7;  rom[1] = 16'hFC10;  // @7  D=M
    rom[2] = 16'hE390;                   // D=D-1
    rom[3] = 16'd8;  rom[4] = 16'hE308;  // @8  M=D
    rom[5] = 16'd5;  rom[6] = 16'hEA87;  // @5  0;JMP
    push_exp(1'b0, 15'd7, 16'd0, 1);
    push_exp(1'b1, 15'd8, 16'd9, 1);
    run = 1'b1;
    wait_halt(100, "read halted");
    chk("read D", 32'(d16), 9);
    chk("read pc", 32'(pc), 5);
    chk("read cycle_count", cc, 16);
    chk("read ram[8]", 32'(ram[8]), 9);

    // Pause mid-program
    do_reset();
    load_add();
    push_exp(1'b1, 15'd0, 16'd5, 1);
    run = 1'b1;
    repeat (5) @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
    pc_snap = pc; cc_snap = cc; req_snap = req_cnt;
    repeat (5) @(negedge clk);
    chk("pause pc", 32'(pc), 32'(pc_snap));
    chk("pause cycle_count", cc, cc_snap);
    chk("pause mem_req cycles", 32'(req_cnt), 32'(req_snap));
    chk("pause not halted", 32'(halted), 0);
    run = 1'b1;
    wait_halt(100, "pause halted");
    chk("pause final cycle_count", cc, 17);
    chk("pause final D", 32'(d16), 5);

    // Reset during MEM_WR with ack withheld, then a stray ack
    do_reset();
    ack_en = 1'b0;
    load_add();
    run = 1'b1;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach MEM_WR", 32'(bus.mem_req && bus.mem_we), 1);
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst mem_req", 32'(bus.mem_req), 0);
    chk("midrst A", 32'(a16), 0);
    chk("midrst D", 32'(d16), 0);
    chk("midrst pc", 32'(pc), 0);
    chk("midrst cycle_count", cc, 0);
    chk("midrst mem_wdata", 32'(bus.mem_wdata), 0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray mem_req", 32'(bus.mem_req), 0);
    chk("stray pc", 32'(pc), 0);
    @(negedge clk);
    chk("stray cycle_count", cc, 0);
    ack_en = 1'b1;
    push_exp(1'b1, 15'd0, 16'd5, 1);
    run = 1'b1;
    wait_halt(100, "post-reset halted");
    chk("post-reset cycle_count", cc, 17);

    // D;JLT on 65534: negative at WIDTH=16, positive at WIDTH=32
    do_reset();
    clear_rom();
    rom[0]  = 16'h7FFF; rom[1]  = 16'hEC10;  // @32767  D=A
    rom[2]  = 16'hE090;                      // D=D+A
    rom[3]  = 16'd10;   rom[4]  = 16'hE304;  // @10  D;JLT
    rom[5]  = 16'd5;    rom[6]  = 16'hEA87;  // @5  0;JMP
    rom[10] = 16'd10;   rom[11] = 16'hEA87;  // @10 0;JMP
    foreach (rom32[i]) rom32[i] = rom[i];
    run = 1'b1;
    run32 = 1'b1;
    n = 0;
    while (!(halted && halted32) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("jlt16 halted", 32'(halted), 1);
    chk("jlt16 D", 32'(d16), 32'h0000_FFFE);
    chk("jlt16 pc", 32'(pc), 10);
    chk("jlt32 halted", 32'(halted32), 1);
    chk("jlt32 D", d32, 32'd65534);
    chk("jlt32 pc", 32'(pc32), 5);

    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
